// File: rtl/engine_round_controller.sv
// AES round sequencer: INIT (pre-round key add), NUM_ROUNDS-1 mixing rounds, FINAL, then DONE until out_ready.
// Optional ENGINE_RC_DECRYPT_EN adds decrypt/inv_mode and a descending round-key index.
module engine_round_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             transformer_start,
  input  logic             out_ready,
`ifdef ENGINE_RC_DECRYPT_EN
  input  logic             decrypt,
  output logic             inv_mode,
`endif
  output logic [IDX_W-1:0] round_idx,
  output logic             state_load,
  output logic             state_en,
  output logic             mix_en,
  output logic             busy,
  output logic             transformer_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LP_ZERO = '0;
  localparam logic [IDX_W-1:0] LP_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] LP_PEN  = IDX_W'(NUM_ROUNDS - 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             w_dec_req;
  logic             w_inv;

`ifdef ENGINE_RC_DECRYPT_EN
  logic r_inv;
  logic w_inv_nxt;

  assign w_dec_req = decrypt;
  assign w_inv     = r_inv;
  assign inv_mode  = r_inv;
  // Direction is captured only when a block is accepted and held for its whole duration.
  assign w_inv_nxt = (r_state == S_IDLE && transformer_start) ? decrypt : r_inv;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_inv <= 1'b0;
    else       r_inv <= w_inv_nxt;
  end
`else
  assign w_dec_req = 1'b0;
  assign w_inv     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    w_idx_nxt   = LP_ZERO;
    case (r_state)
      S_IDLE: begin
        if (transformer_start) begin
          w_state_nxt = S_INIT;
          w_idx_nxt   = w_dec_req ? LP_LAST : LP_ZERO;
        end
      end
      S_INIT: begin
        w_state_nxt = S_ROUND;
        w_idx_nxt   = w_inv ? LP_PEN : LP_ONE;
      end
      S_ROUND: begin
        // The last mixing round hands straight over to the final-round key index.
        if (r_idx == (w_inv ? LP_ONE : LP_PEN)) begin
          w_state_nxt = S_FINAL;
          w_idx_nxt   = w_inv ? LP_ZERO : LP_LAST;
        end else begin
          w_state_nxt = S_ROUND;
          w_idx_nxt   = w_inv ? (r_idx - LP_ONE) : (r_idx + LP_ONE);
        end
      end
      S_FINAL: begin
        w_state_nxt = S_DONE;
        w_idx_nxt   = r_idx;
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = LP_ZERO;
        end else begin
          w_state_nxt = S_DONE;
          w_idx_nxt   = r_idx;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = LP_ZERO;
      end
    endcase
  end

  assign round_idx        = r_idx;
  assign state_load       = (r_state == S_INIT);
  assign state_en         = (r_state == S_ROUND) || (r_state == S_FINAL);
  assign mix_en           = (r_state == S_ROUND);
  assign busy             = (r_state == S_INIT) || (r_state == S_ROUND) || (r_state == S_FINAL);
  assign transformer_done = (r_state == S_DONE);

endmodule
